raminfr: RTL and testbench
==========================

// Module: raminfr
// PURPOSE
//   Single-port 32x4 RAM: synchronous write, asynchronous (combinational) read.
//   Small register-file-style store for control/config data; infers flops or distributed RAM.
//   One shared address bus serves both write and read.
//   Asynchronous active-high reset clears the whole array.
// PARAMETERS
//   ADDR_W  5   address width; DEPTH = 2**ADDR_W words (32)
//   DATA_W  4   word width in bits
// PORTS
//   clk   in   1       single clock; all writes on rising edge
//   rst   in   1       reset, asynchronous, active-high
//   we    in   1       write enable, sampled at rising clk
//   a     in   ADDR_W  address, shared by read and write
//   di    in   DATA_W  write data
//   do    out  DATA_W  read data = mem[a], combinational
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is asynchronous and active-high.
//   - Reset:
//     - rst=1 immediately clears all DEPTH words to 0, no clock needed.
//     - do therefore reads 0 while rst=1 and at any address afterwards until written.
//     - Writes are blocked while rst=1.
//   - Write: at posedge clk with rst=0 and we=1, mem[a] <= di.
//     - One write per cycle; no byte enables.
//     - we=0: array unchanged.
//   - Read: do = mem[a] continuously, zero-cycle latency.
//     - A change on a updates do within the same delta/comb path; no clock involved.
//   - Read-during-write, same address:
//     - do shows the old contents until the rising edge.
//     - The new value (di) appears right after the edge; no bypass before the edge.
//   - Addressing:
//     - All 2**ADDR_W addresses are valid; no out-of-range case.
//     - a is exactly ADDR_W bits, so there is no wrap logic.
//   - Reset mid-operation:
//     - rst asserting in the same cycle as a write edge: reset wins, word ends at 0.
//     - Deassertion takes effect at the next clk edge.
//   - do never X after the first reset; no internal state other than the array.
// STRUCTURE
//   - Shared package ram_pkg: ADDR_W, DATA_W, DEPTH constants and
//     typedef logic [DATA_W-1:0] word_t, typedef logic [ADDR_W-1:0] addr_t.
//   - Array: mem[0:DEPTH-1], built as one flop-array always block with async clear.
//   - Read path: a single continuous assign mux.
//   - No sub-module; the block is flat.
// TESTING
//   - Reset: rst=1 then 0 -> do=0000 at a=0, 4, 15, 31.
//   - Write/read: negedge set we=1,a=4,di=1010; next a=8,di=1100; then we=0.
//     Read a=4 -> 1010, a=8 -> 1100, a=15 -> 0000 (never written).
//   - Write-enable low: we=0, a=4, di=0110 over several edges -> a=4 still reads 1010.
//   - Async read / RDW: we=1, a=20, di=0011; do=0000 before the edge, 0011 after it.
//     Toggle a between 4 and 20 with no clock -> do follows immediately.
//   - Boundaries: write a=0 -> 0001 and a=31 -> 1111; both read back; a=1 and a=30 stay 0000.
//   - Reset mid-op: pulse rst between clock edges after the writes above.
//     All addresses read 0000 at once; a write on the edge coinciding with rst is ignored.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared sizing constants and word/address types for the raminfr store.
//   ADDR_W : address width (5)   -> DEPTH = 32 words
//   DATA_W : word width (4)
//   word_t : one stored word
//   addr_t : one address
package ram_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/raminfr.sv
// raminfr
//   Single-port 32x4 store for control/config data: synchronous write,
//   combinational read, one shared address bus. An asynchronous
//   active-high reset clears every word.
// Ports
//   clk  in   1       write clock, rising edge
//   rst  in   1       asynchronous active-high clear of the whole array
//   we   in   1       write enable, sampled at rising clk
//   a    in   ADDR_W  address for both read and write
//   di   in   DATA_W  write data
//   dout out  DATA_W  read data = mem[a], combinational
//   (the read-data port is called dout because "do" is a reserved word)
module raminfr
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];

    // Next array contents: only the addressed word changes, and only with we.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[a] = di;
        end
    end

    // Reset has priority, so a write edge coinciding with rst is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Zero-latency read; shows the pre-edge word during a same-address write.
    assign dout = mem_q[a];

endmodule : raminfr

// File: tb/tb_raminfr.sv
module tb_raminfr;
    import ram_pkg::*;

    typedef struct {
        string name;
        word_t exp;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  we  = 1'b0;
    addr_t a   = '0;
    word_t di  = '0;
    word_t dout;

    exp_t  sb_q [$];
    event  sample_ev;
    int    total = 0;
    int    bad   = 0;

    raminfr dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .a    (a),
        .di   (di),
        .dout (dout)
    );

    always #5 clk = ~clk;

    // Monitor: each sample strobe means the DUT output is presented; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sample_without_expect: got=%b", dout);
            end else begin
                e = sb_q.pop_front();
                if (dout !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got=%b want=%b", e.name, dout, e.exp);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input word_t exp);
        exp_t e;
        #1;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic rd(input string name, input addr_t addr, input word_t exp);
        a = addr;
        expect_rd(name, exp);
    endtask

    task automatic wr(input addr_t addr, input word_t data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        di = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        // Reset, checked while asserted and after release.
        rd("rst_active_a0", 5'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        rd("rst_a0", 5'd0, 4'b0000);
        rd("rst_a4", 5'd4, 4'b0000);
        rd("rst_a15", 5'd15, 4'b0000);
        rd("rst_a31", 5'd31, 4'b0000);

        // Back-to-back writes.
        @(negedge clk);
        we = 1'b1; a = 5'd4; di = 4'b1010;
        @(negedge clk);
        a = 5'd8; di = 4'b1100;
        @(negedge clk);
        we = 1'b0;
        rd("wr_a4", 5'd4, 4'b1010);
        rd("wr_a8", 5'd8, 4'b1100);
        rd("unwritten_a15", 5'd15, 4'b0000);

        // we low over several edges.
        @(negedge clk);
        a = 5'd4; di = 4'b0110;
        repeat (3) @(negedge clk);
        rd("we_low_a4", 5'd4, 4'b1010);

        // Read-during-write at a=20.
        @(negedge clk);
        we = 1'b1; a = 5'd20; di = 4'b0011;
        expect_rd("rdw_before_edge", 4'b0000);
        @(posedge clk);
        expect_rd("rdw_after_edge", 4'b0011);
        we = 1'b0;

        // Address toggling with no write: output follows combinationally.
        rd("async_a4", 5'd4, 4'b1010);
        rd("async_a20", 5'd20, 4'b0011);
        rd("async_a4_again", 5'd4, 4'b1010);

        // Boundary addresses.
        wr(5'd0, 4'b0001);
        wr(5'd31, 4'b1111);
        rd("bnd_a0", 5'd0, 4'b0001);
        rd("bnd_a31", 5'd31, 4'b1111);
        rd("bnd_a1", 5'd1, 4'b0000);
        rd("bnd_a30", 5'd30, 4'b0000);

        // Reset pulse between edges clears everything at once.
        @(negedge clk);
        #1 rst = 1'b1;
        rd("midrst_a4", 5'd4, 4'b0000);
        rd("midrst_a8", 5'd8, 4'b0000);
        rd("midrst_a20", 5'd20, 4'b0000);
        rd("midrst_a31", 5'd31, 4'b0000);

        // Write attempted on an edge while rst is held: ignored.
        @(negedge clk);
        we = 1'b1; a = 5'd5; di = 4'b1111;
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        rd("rst_blocks_wr_a5", 5'd5, 4'b0000);

        // Normal writing resumes after release.
        wr(5'd5, 4'b0101);
        rd("post_rst_wr_a5", 5'd5, 4'b0101);
        rd("post_rst_a0", 5'd0, 4'b0000);

        #5;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_raminfr
